// File: rtl/cwbp_pkg.sv
// Shared types and pointer decode helpers for the CWBP command prefetcher.
// Pointers carry {way, row}; an all-ones pointer marks an unmapped entry.
package cwbp_pkg;

    localparam int WAY_W = 4;
    localparam int PTR_MAX = 64;
    localparam logic [PTR_MAX-1:0] UNMAPPED_PTR = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic logic [WAY_W-1:0] ptr_way(
        input logic [PTR_MAX-1:0] ptr,
        input int unsigned        w
    );
        return WAY_W'(ptr >> (w - WAY_W));
    endfunction

    function automatic logic [PTR_MAX-1:0] ptr_row(
        input logic [PTR_MAX-1:0] ptr,
        input int unsigned        w
    );
        return ptr & ((PTR_MAX'(1) << (w - WAY_W)) - PTR_MAX'(1));
    endfunction

endpackage

// File: rtl/cwbp_cmd_fifo.sv
// Synchronous command FIFO with occupancy count and same-cycle push/pop.
// mark_last sets the flag bit (bit 0) of the most recently written entry.
module cwbp_cmd_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    mark_last,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end else if (mark_last && (count != '0)) begin
            mem[wr_ptr - AW'(1)][0] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/cwbp_cmd_prefetch.sv
// Counted, back-pressured prefetch of CWBP mapping pointers from BRAM
// into a {way,row,last} command queue feeding the M01 AXI master.
module cwbp_cmd_prefetch
    import cwbp_pkg::*;
#(
    parameter logic [31:0] START_ADDR = 32'h4580_0000,
    parameter int          DATA_WIDTH = 32,
    parameter int          FIFO_DEPTH = 8,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  entry_count,
    output logic                  ram_clk,
    output logic                  ram_rst,
    output logic                  ram_en,
    output logic [31:0]           ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [3:0]            ram_we,
    output logic [31:0]           ram_wd_data,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [WAY_W-1:0]      cmd_way,
    output logic [DATA_WIDTH-1:0] cmd_row,
    output logic                  cmd_last,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  skipped
);

    localparam int EW = WAY_W + DATA_WIDTH + 1;
    localparam int QW = $clog2(FIFO_DEPTH) + 1;

    state_e                 state;
    logic [CNT_WIDTH-1:0]   idx;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   inflight;
    logic                   cap_last;
    logic [QW-1:0]          fifo_count;
    logic [QW:0]            occ;
    logic [EW-1:0]          fifo_din;
    logic [EW-1:0]          fifo_dout;
    logic [PTR_MAX-1:0]     ptr_ext;
    logic                   rd_issue;
    logic                   final_idx;
    logic                   cap_unmapped;
    logic                   push;
    logic                   pop;
    logic                   mark_tail;
    logic                   fetch_done;
    logic                   out_fire;
    logic                   out_valid;
    logic                   out_last;
    logic [WAY_W-1:0]       out_way;
    logic [DATA_WIDTH-1:0]  out_row;

    assign ram_clk     = clk;
    assign ram_rst     = rst;
    assign ram_we      = 4'h0;
    assign ram_wd_data = 32'h0;
    assign ram_addr    = START_ADDR + (32'(idx) << 2);

    // Output register counts as queue space, so total storage never exceeds FIFO_DEPTH.
    assign occ = (QW+1)'(fifo_count) + (QW+1)'(out_valid)
               + (QW+1)'(inflight);
    assign rd_issue  = (state == FETCH) && (occ < (QW+1)'(FIFO_DEPTH));
    assign ram_en    = rd_issue;
    assign final_idx = (idx == cnt - CNT_WIDTH'(1));

    assign ptr_ext      = PTR_MAX'(ram_rd_data);
    assign cap_unmapped = (ram_rd_data == UNMAPPED_PTR[DATA_WIDTH-1:0]);
    assign push         = inflight && !cap_unmapped;
    assign mark_tail    = inflight && cap_unmapped && cap_last;
    assign fifo_din     = {ptr_way(ptr_ext, DATA_WIDTH),
                           DATA_WIDTH'(ptr_row(ptr_ext, DATA_WIDTH)),
                           cap_last};

    // The newest entry stays queued until the final read lands, so a
    // late last flag always has an entry to attach to.
    assign fetch_done = (state == DRAIN) && !inflight;
    assign out_fire   = out_valid && cmd_ready;
    assign pop        = (fifo_count != '0) && (!out_valid || cmd_ready)
                      && ((fifo_count > QW'(1)) || fetch_done);

    cwbp_cmd_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .mark_last (mark_tail),
        .din       (fifo_din),
        .dout      (fifo_dout),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            inflight <= 1'b0;
            cap_last <= 1'b0;
            skipped  <= '0;
        end else begin
            inflight <= rd_issue;
            cap_last <= rd_issue && final_idx;
            if (inflight && cap_unmapped && (skipped != '1)) begin
                skipped <= skipped + CNT_WIDTH'(1);
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= entry_count;
                        idx     <= '0;
                        skipped <= '0;
                        state   <= (entry_count != '0) ? FETCH : DONE;
                    end
                end
                FETCH: begin
                    if (rd_issue) begin
                        idx <= idx + CNT_WIDTH'(1);
                        if (final_idx) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!inflight && (fifo_count == '0) && !out_valid) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_way   <= '0;
            out_row   <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            {out_way, out_row, out_last} <= fifo_dout;
        end else if (out_fire) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    assign cmd_valid = out_valid;
    assign cmd_way   = out_way;
    assign cmd_row   = out_row;
    assign cmd_last  = out_last;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_cwbp_cmd_prefetch.sv
// Randomized self-checking bench for cwbp_cmd_prefetch with a
// queue-based reference of the expected command stream.
module tb_cwbp_cmd_prefetch;

    localparam logic [31:0] START = 32'h4580_0000;
    localparam logic [31:0] UNMAP = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] entry_count;
    logic        ram_clk;
    logic        ram_rst;
    logic        ram_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_rd_data;
    logic [3:0]  ram_we;
    logic [31:0] ram_wd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_way;
    logic [31:0] cmd_row;
    logic        cmd_last;
    logic        busy;
    logic        done;
    logic [15:0] skipped;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] bram [64];
    logic [35:0] exp_q [$];
    logic [35:0] e;
    logic        hold_pend;
    logic [36:0] hold_val;
    int          r;

    cwbp_cmd_prefetch dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .entry_count (entry_count),
        .ram_clk     (ram_clk),
        .ram_rst     (ram_rst),
        .ram_en      (ram_en),
        .ram_addr    (ram_addr),
        .ram_rd_data (ram_rd_data),
        .ram_we      (ram_we),
        .ram_wd_data (ram_wd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_way     (cmd_way),
        .cmd_row     (cmd_row),
        .cmd_last    (cmd_last),
        .busy        (busy),
        .done        (done),
        .skipped     (skipped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial ram_rd_data = '0;
    always @(posedge clk) begin
        if (ram_en) ram_rd_data <= bram[6'((ram_addr - START) >> 2)];
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: in-order way/row, last only on the final expected entry.
    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("cmd_hold_valid", cmd_valid, 1);
                chk("cmd_hold_data", {cmd_last, cmd_way, cmd_row}, hold_val);
            end
            if (cmd_valid && cmd_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_cmd", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd_way", cmd_way, e[35:32]);
                    chk("cmd_row", cmd_row, e[31:0]);
                    chk("cmd_last", cmd_last, exp_q.size() == 0);
                end
            end
            hold_pend = cmd_valid && !cmd_ready;
            hold_val  = {cmd_last, cmd_way, cmd_row};
        end
    end

    task automatic run(input int n, input int pct, input int hold,
                       input bit spur, output int rd_hold);
        int  exp_skip = 0;
        int  rd_idx = 0;
        int  dcnt = 0;
        bit  ok = 0;
        for (int i = 0; i < n; i++) begin
            if (bram[i] == UNMAP) exp_skip++;
            else exp_q.push_back({bram[i][31:28], 4'h0, bram[i][27:0]});
        end
        rd_hold = 0;
        tick;
        entry_count = 16'(n);
        start = 1'b1;
        tick;
        start = 1'b0;
        entry_count = 16'($urandom);
        for (int c = 0; c < 4000; c++) begin
            cmd_ready = (c < hold) ? 1'b0 : ($urandom_range(99) < pct);
            start = spur && (c == 0);
            @(negedge clk);
            if (n == 0 && c == 0) chk("zero_done_now", done, 1);
            if (done) dcnt++;
            if (ram_en) begin
                chk("ram_addr", ram_addr, 32'(START + 32'(4 * rd_idx)));
                rd_idx++;
                if (c < hold) rd_hold++;
            end
            if (!busy && dcnt > 0) begin
                ok = 1;
                break;
            end
            tick;
        end
        start = 1'b0;
        cmd_ready = 1'b0;
        chk("run_finished", ok, 1);
        chk("done_cycles", dcnt, 1);
        chk("reads", rd_idx, n);
        chk("skipped", skipped, exp_skip);
        chk("exp_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        entry_count = '0;
        cmd_ready = 1'b0;
        for (int i = 0; i < 64; i++) bram[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_addr", ram_addr, START);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_last", cmd_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_skipped", skipped, 0);
        chk("rst_ram_we", {ram_we, ram_wd_data}, 0);
        tick;
        rst = 1'b0;

        // T1 basic run
        for (int i = 0; i < 4; i++) bram[i] = 32'h1000_0010 + 32'(i);
        run(4, 100, 0, 0, r);

        // T2 long stall then release
        for (int i = 0; i < 12; i++) bram[i] = {4'(i), 28'($urandom)};
        run(12, 100, 50, 0, r);
        chk("t2_reads_held", r, 8);

        // T3 unmapped middle entry
        bram[0] = 32'h2000_0100;
        bram[1] = UNMAP;
        bram[2] = 32'h3000_0102;
        run(3, 100, 0, 0, r);

        // T4 unmapped final entry
        bram[0] = 32'h5000_0200;
        bram[1] = UNMAP;
        run(2, 100, 20, 0, r);

        // T5 empty run with start during busy
        run(0, 100, 0, 1, r);

        // all entries unmapped
        for (int i = 0; i < 3; i++) bram[i] = UNMAP;
        run(3, 100, 0, 0, r);

        // T6 reset during fetch
        for (int i = 0; i < 12; i++) bram[i] = {4'h3, 28'(i)};
        bram[1] = UNMAP;
        tick;
        entry_count = 16'd12;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (8) tick;
        @(negedge clk);
        chk("t6_pre_valid", cmd_valid, 1);
        chk("t6_pre_busy", busy, 1);
        tick;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_cmd_valid", cmd_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ram_en", ram_en, 0);
        chk("t6_ram_addr", ram_addr, START);
        chk("t6_skipped", skipped, 0);
        tick;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) bram[i] = {4'h7, 28'(i + 16)};
        run(5, 100, 0, 0, r);

        // randomized runs
        for (int k = 0; k < 10; k++) begin
            int n;
            n = $urandom_range(40, 1);
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(99) < 25) bram[i] = UNMAP;
                else bram[i] = {4'($urandom), 28'($urandom)};
            end
            run(n, $urandom_range(100, 20),
                ($urandom_range(3) == 0) ? $urandom_range(40, 1) : 0,
                1'($urandom), r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
